// File: rtl/imm_gen_pipe.sv
// RV32I/RV64I immediate generator: combinational decode of the incoming word
// feeding a two-entry (main + skid) output buffer with a registered in_ready.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_J     = 3'd4;
  localparam logic [2:0] FMT_U     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } ent_t;

  function automatic ent_t decode(input logic [31:0] inst, input logic [TAG_W-1:0] tag);
    ent_t              e;
    logic        [6:0] opc;
    logic        [2:0] f3;
    logic              is_sh;
    logic signed [11:0] i12;
    logic signed [11:0] s12;
    logic signed [12:0] b13;
    logic signed [20:0] j21;
    logic signed [31:0] u32;
    opc   = inst[6:0];
    f3    = inst[14:12];
    is_sh = (f3 == 3'b001) || (f3 == 3'b101);
    i12   = inst[31:20];
    s12   = {inst[31:25], inst[11:7]};
    b13   = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    j21   = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    u32   = {inst[31:12], 12'b0};
    e.imm = '0;
    e.fmt = FMT_NONE;
    e.ill = 1'b1;
    e.tag = tag;
    if (inst[1:0] == 2'b11) begin
      case (opc)
        7'b0010011: begin
          if (is_sh) begin
            // RV32 shift amounts are 5 bits; inst[25] set there is reserved
            if (!(XLEN == 32 && inst[25])) begin
              e.fmt = FMT_SHAMT;
              e.ill = 1'b0;
              e.imm = (XLEN == 64) ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
            end
          end else begin
            e.fmt = FMT_I;
            e.ill = 1'b0;
            e.imm = XLEN'(i12);
          end
        end
        7'b0011011: begin
          if (XLEN == 64) begin
            e.ill = 1'b0;
            if (is_sh) begin
              e.fmt = FMT_SHAMT;
              e.imm = XLEN'(inst[24:20]);
            end else begin
              e.fmt = FMT_I;
              e.imm = XLEN'(i12);
            end
          end
        end
        7'b0000011, 7'b1100111, 7'b1110011: begin
          e.fmt = FMT_I;
          e.ill = 1'b0;
          e.imm = XLEN'(i12);
        end
        7'b0100011: begin
          e.fmt = FMT_S;
          e.ill = 1'b0;
          e.imm = XLEN'(s12);
        end
        7'b1100011: begin
          e.fmt = FMT_B;
          e.ill = 1'b0;
          e.imm = XLEN'(b13);
        end
        7'b1101111: begin
          e.fmt = FMT_J;
          e.ill = 1'b0;
          e.imm = XLEN'(j21);
        end
        7'b0110111, 7'b0010111: begin
          e.fmt = FMT_U;
          e.ill = 1'b0;
          e.imm = XLEN'(u32);
        end
        default: ;
      endcase
    end
    return e;
  endfunction

  ent_t w_dec;
  logic w_acc;
  logic w_fire;
  logic w_skid_vld_nxt;

  ent_t r_main;
  logic r_main_vld;
  ent_t r_skid;
  logic r_skid_vld;
  logic r_in_ready;

  assign w_dec  = decode(in_inst, in_tag);
  assign w_acc  = in_valid && r_in_ready;
  assign w_fire = r_main_vld && out_ready;

  always_comb begin
    w_skid_vld_nxt = r_skid_vld;
    if (r_skid_vld) begin
      if (w_fire) w_skid_vld_nxt = 1'b0;
    end else if (w_acc && r_main_vld && !w_fire) begin
      w_skid_vld_nxt = 1'b1;
    end
  end

  // Stage boundary: main entry drives the outputs directly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main     <= '0;
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      if (!r_main_vld || w_fire) begin
        if (r_skid_vld) begin
          r_main     <= r_skid;
          r_main_vld <= 1'b1;
        end else if (w_acc) begin
          r_main     <= w_dec;
          r_main_vld <= 1'b1;
        end else begin
          r_main_vld <= 1'b0;
        end
      end
      r_skid_vld <= w_skid_vld_nxt;
      r_in_ready <= !w_skid_vld_nxt;
    end
  end

  // Skid payload is only meaningful while r_skid_vld is set
  always_ff @(posedge clk) begin
    if (w_acc && r_main_vld && !w_fire) r_skid <= w_dec;
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_main_vld;
  assign out_imm     = r_main.imm;
  assign out_fmt     = r_main.fmt;
  assign out_illegal = r_main.ill;
  assign out_tag     = r_main.tag;

endmodule
